// File: rtl/exu_bru.sv
`default_nettype none
// ============================================================================
// Module   : exu_bru
// Purpose  : Branch resolution unit. Evaluates conditional branches and
//            jal/jalr, produces the resolved next PC and the link address,
//            detects mispredictions against the front-end prediction, keeps
//            a table of 2-bit taken/not-taken counters and counts redirects.
// Ports    : clk, rst_n              clock, asynchronous active-low reset
//            i_valid/o_ready         request handshake
//            i_op, i_rs1, i_rs2,     operation, operands, immediate, PC
//            i_imm, i_pc
//            i_predict_flag/_target  front-end prediction for this branch
//            o_valid/i_ready         result handshake
//            o_taken, o_pc, o_link   resolved direction, next PC, pc+4
//            o_pipe_flush            redirect pulse on a mispredicted transfer
//            i_kill                  discard the held result
//            i_lookup_pc,            counter table lookup (pre-update value)
//            o_lookup_taken
//            o_mispredict_cnt        saturating redirect counter
// Revision : 1.0 - initial release
// ============================================================================
module exu_bru #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [2:0]           i_op,
  input  logic [XLEN-1:0]      i_rs1,
  input  logic [XLEN-1:0]      i_rs2,
  input  logic [XLEN-1:0]      i_imm,
  input  logic [XLEN-1:0]      i_pc,
  input  logic                 i_predict_flag,
  input  logic [XLEN-1:0]      i_predict_target,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_taken,
  output logic [XLEN-1:0]      o_pc,
  output logic [XLEN-1:0]      o_link,
  output logic                 o_pipe_flush,
  input  logic                 i_kill,
  input  logic [XLEN-1:0]      i_lookup_pc,
  output logic                 o_lookup_taken,
  output logic [CNT_WIDTH-1:0] o_mispredict_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [2:0] OP_BEQ  = 3'd0;
  localparam logic [2:0] OP_BNE  = 3'd1;
  localparam logic [2:0] OP_BLT  = 3'd2;
  localparam logic [2:0] OP_BGE  = 3'd3;
  localparam logic [2:0] OP_BLTU = 3'd4;
  localparam logic [2:0] OP_BGEU = 3'd5;
  localparam logic [2:0] OP_JALR = 3'd7;

  localparam logic [1:0] CTR_INIT = 2'b01;
  localparam logic [1:0] CTR_MAX  = 2'b11;
  localparam logic [1:0] CTR_MIN  = 2'b00;

  // Resolution of the incoming request
  logic            eq;
  logic            lt_s;
  logic            lt_u;
  logic            taken_c;
  logic            mispred_c;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] pc_plus_4;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target_c;

  always_comb begin
    eq          = (i_rs1 == i_rs2);
    lt_s        = ($signed(i_rs1) < $signed(i_rs2));
    lt_u        = (i_rs1 < i_rs2);
    pc_plus_imm = i_pc + i_imm;
    pc_plus_4   = i_pc + XLEN'(4);
    jalr_sum    = i_rs1 + i_imm;
    case (i_op)
      OP_BEQ:  taken_c = eq;
      OP_BNE:  taken_c = ~eq;
      OP_BLT:  taken_c = lt_s;
      OP_BGE:  taken_c = ~lt_s;
      OP_BLTU: taken_c = lt_u;
      OP_BGEU: taken_c = ~lt_u;
      default: taken_c = 1'b1;
    endcase
    // jalr always jumps; its target ignores the PC and drops bit 0
    if (i_op == OP_JALR) begin
      target_c = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (taken_c) begin
      target_c = pc_plus_imm;
    end else begin
      target_c = pc_plus_4;
    end
    // Target only matters when both sides agree the branch is taken
    mispred_c = (taken_c != i_predict_flag) |
                (taken_c & i_predict_flag & (target_c != i_predict_target));
  end

  // Result register and handshake
  logic                 valid_q, valid_d;
  logic                 taken_q, taken_d;
  logic                 mispred_q, mispred_d;
  logic                 cond_q, cond_d;
  logic [XLEN-1:0]      pc_q, pc_d;
  logic [XLEN-1:0]      link_q, link_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [1:0]           bht_q [BHT_DEPTH];
  logic [1:0]           bht_d [BHT_DEPTH];
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 accept;
  logic                 xfer;
  logic                 unused_lookup_bits;

  assign o_ready      = ~valid_q | i_ready;
  // A kill discards both the held result and anything arriving alongside it
  assign accept       = i_valid & o_ready & ~i_kill;
  assign xfer         = valid_q & i_ready & ~i_kill;
  assign o_pipe_flush = xfer & mispred_q;

  always_comb begin
    valid_d   = valid_q;
    taken_d   = taken_q;
    mispred_d = mispred_q;
    cond_d    = cond_q;
    pc_d      = pc_q;
    link_d    = link_q;
    idx_d     = idx_q;
    if (i_kill) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      taken_d   = taken_c;
      mispred_d = mispred_c;
      cond_d    = (i_op <= OP_BGEU);
      pc_d      = target_c;
      link_d    = pc_plus_4;
      idx_d     = i_pc[2 +: IDX_W];
    end
  end

  // Counter table trains only on conditional branches that actually leave
  always_comb begin
    for (int i = 0; i < BHT_DEPTH; i++) begin
      bht_d[i] = bht_q[i];
    end
    if (xfer && cond_q) begin
      if (taken_q) begin
        if (bht_q[idx_q] != CTR_MAX) bht_d[idx_q] = bht_q[idx_q] + 2'b01;
      end else begin
        if (bht_q[idx_q] != CTR_MIN) bht_d[idx_q] = bht_q[idx_q] - 2'b01;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (o_pipe_flush && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      taken_q   <= 1'b0;
      mispred_q <= 1'b0;
      cond_q    <= 1'b0;
      pc_q      <= '0;
      link_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= CTR_INIT;
      end
    end else begin
      valid_q   <= valid_d;
      taken_q   <= taken_d;
      mispred_q <= mispred_d;
      cond_q    <= cond_d;
      pc_q      <= pc_d;
      link_q    <= link_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

  assign o_valid          = valid_q;
  assign o_taken          = taken_q;
  assign o_pc             = pc_q;
  assign o_link           = link_q;
  assign o_mispredict_cnt = cnt_q;
  // Read straight from the flops so a same-cycle update is not visible
  assign o_lookup_taken   = bht_q[i_lookup_pc[2 +: IDX_W]][1];

  // Only the index field of the lookup PC selects a counter
  assign unused_lookup_bits = ^i_lookup_pc;

endmodule
`default_nettype wire

// File: tb/tb_exu_bru.sv
`default_nettype none
// ============================================================================
// Module   : tb_exu_bru
// Purpose  : Self-checking bench for exu_bru against a behavioural model of
//            branch resolution, counter training and redirect counting.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exu_bru;
  localparam int XLEN      = 32;
  localparam int BHT_DEPTH = 16;
  localparam int CNT_WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 i_valid = 1'b0;
  logic                 o_ready;
  logic [2:0]           i_op = '0;
  logic [XLEN-1:0]      i_rs1 = '0, i_rs2 = '0, i_imm = '0, i_pc = '0;
  logic                 i_predict_flag = 1'b0;
  logic [XLEN-1:0]      i_predict_target = '0;
  logic                 o_valid;
  logic                 i_ready = 1'b1;
  logic                 o_taken;
  logic [XLEN-1:0]      o_pc, o_link;
  logic                 o_pipe_flush;
  logic                 i_kill = 1'b0;
  logic [XLEN-1:0]      i_lookup_pc = '0;
  logic                 o_lookup_taken;
  logic [CNT_WIDTH-1:0] o_mispredict_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: counters and redirect count
  int bht_m [BHT_DEPTH];
  int cnt_m;

  exu_bru #(.XLEN(XLEN), .BHT_DEPTH(BHT_DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .i_pc(i_pc),
    .i_predict_flag(i_predict_flag), .i_predict_target(i_predict_target),
    .o_valid(o_valid), .i_ready(i_ready), .o_taken(o_taken), .o_pc(o_pc),
    .o_link(o_link), .o_pipe_flush(o_pipe_flush), .i_kill(i_kill),
    .i_lookup_pc(i_lookup_pc), .o_lookup_taken(o_lookup_taken),
    .o_mispredict_cnt(o_mispredict_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % BHT_DEPTH);
  endfunction

  function automatic bit pred_bit(input logic [31:0] pc);
    return bht_m[idx_of(pc)] >= 2;
  endfunction

  function automatic void model_eval(input logic [2:0] op, input logic [31:0] rs1, rs2, imm, pc,
                                     output bit tk, output logic [31:0] tgt, output logic [31:0] lnk);
    longint s1, s2;
    s1 = longint'($signed(rs1));
    s2 = longint'($signed(rs2));
    case (op)
      3'd0: tk = (rs1 == rs2);
      3'd1: tk = (rs1 != rs2);
      3'd2: tk = (s1 < s2);
      3'd3: tk = (s1 >= s2);
      3'd4: tk = ({32'd0, rs1} < {32'd0, rs2});
      3'd5: tk = ({32'd0, rs1} >= {32'd0, rs2});
      default: tk = 1'b1;
    endcase
    if (op == 3'd7)  tgt = 32'((64'(rs1) + 64'(imm)) / 2 * 2);
    else if (tk)     tgt = 32'(64'(pc) + 64'(imm));
    else             tgt = 32'(64'(pc) + 64'd4);
    lnk = 32'(64'(pc) + 64'd4);
  endfunction

  function automatic bit model_mis(input bit tk, input bit pf, input logic [31:0] tgt, pt);
    return (tk != pf) || (tk && pf && (tgt != pt));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < BHT_DEPTH; i++) bht_m[i] = 1;
    cnt_m = 0;
  endfunction

  function automatic void model_commit(input logic [2:0] op, input logic [31:0] pc, input bit tk, input bit mis);
    int k;
    k = idx_of(pc);
    if (op <= 3'd5) begin
      if (tk && bht_m[k] < 3) bht_m[k] = bht_m[k] + 1;
      if (!tk && bht_m[k] > 0) bht_m[k] = bht_m[k] - 1;
    end
    if (mis && cnt_m < (1 << CNT_WIDTH) - 1) cnt_m = cnt_m + 1;
  endfunction

  task automatic drive_req(input logic [2:0] op, input logic [31:0] rs1, rs2, imm, pc,
                           input bit pf, input logic [31:0] pt);
    i_valid = 1'b1; i_op = op; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm; i_pc = pc;
    i_predict_flag = pf; i_predict_target = pt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_kill = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", o_valid); end
    n_tests++; if (o_taken !== 1'b0 || o_pc !== '0 || o_link !== '0) begin n_fail++;
      $display("FAIL reset_result got taken=%b pc=%h link=%h exp 0", o_taken, o_pc, o_link); end
    n_tests++; if (o_pipe_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b exp 0", o_pipe_flush); end
    n_tests++; if (o_mispredict_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", o_mispredict_cnt); end
    for (int i = 0; i < BHT_DEPTH; i++) begin
      i_lookup_pc = 32'(i * 4); #1;
      n_tests++; if (o_lookup_taken !== 1'b0) begin n_fail++; $display("FAIL reset_bht idx=%0d got %b exp 0", i, o_lookup_taken); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One isolated request with i_ready high: checks the result cycle and the idle cycle after
  task automatic test_single_txn(input logic [2:0] op, input logic [31:0] rs1, rs2, imm, pc,
                                 input bit pf, input logic [31:0] pt);
    bit tk, mis;
    logic [31:0] tgt, lnk;
    model_eval(op, rs1, rs2, imm, pc, tk, tgt, lnk);
    mis = model_mis(tk, pf, tgt, pt);
    drive_req(op, rs1, rs2, imm, pc, pf, pt); i_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    i_valid = 1'b0; i_lookup_pc = pc; #1;
    n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL txn_valid op=%0d got %b exp 1", op, o_valid); end
    n_tests++; if (o_taken !== tk) begin n_fail++; $display("FAIL txn_taken op=%0d got %b exp %b", op, o_taken, tk); end
    n_tests++; if (o_pc !== tgt) begin n_fail++; $display("FAIL txn_pc op=%0d got %h exp %h", op, o_pc, tgt); end
    n_tests++; if (o_link !== lnk) begin n_fail++; $display("FAIL txn_link op=%0d got %h exp %h", op, o_link, lnk); end
    n_tests++; if (o_pipe_flush !== mis) begin n_fail++; $display("FAIL txn_flush op=%0d got %b exp %b", op, o_pipe_flush, mis); end
    n_tests++; if (o_lookup_taken !== pred_bit(pc)) begin n_fail++;
      $display("FAIL txn_lookup_pre op=%0d got %b exp %b", op, o_lookup_taken, pred_bit(pc)); end
    model_commit(op, pc, tk, mis);
    @(posedge clk); @(negedge clk);
    n_tests++; if (o_valid !== 1'b0 || o_pipe_flush !== 1'b0) begin n_fail++;
      $display("FAIL txn_idle op=%0d got valid=%b flush=%b exp 0/0", op, o_valid, o_pipe_flush); end
    n_tests++; if (o_mispredict_cnt !== CNT_WIDTH'(cnt_m)) begin n_fail++;
      $display("FAIL txn_cnt op=%0d got %0d exp %0d", op, o_mispredict_cnt, cnt_m); end
    n_tests++; if (o_lookup_taken !== pred_bit(pc)) begin n_fail++;
      $display("FAIL txn_lookup_post op=%0d got %b exp %b", op, o_lookup_taken, pred_bit(pc)); end
  endtask

  task automatic test_directed();
    test_single_txn(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 1'b0, 32'h0);  // bltu: not taken
    test_single_txn(3'd2, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 1'b0, 32'h0);  // blt: taken, flush
    test_single_txn(3'd7, 32'h203, 32'd0, 32'd0, 32'h500, 1'b1, 32'h202);       // jalr correct
    test_single_txn(3'd7, 32'h203, 32'd0, 32'd0, 32'h500, 1'b1, 32'h200);       // jalr wrong target
    test_single_txn(3'd6, 32'd0, 32'd0, 32'h40, 32'h600, 1'b1, 32'h640);        // jal correct
    test_single_txn(3'd3, 32'h8000_0000, 32'd1, 32'h10, 32'h44, 1'b1, 32'h54);  // bge signed
    test_single_txn(3'd5, 32'h8000_0000, 32'd1, 32'h10, 32'h48, 1'b0, 32'h0);   // bgeu unsigned
  endtask

  task automatic test_reset_mid();
    drive_req(3'd0, 32'd7, 32'd7, 32'h8, 32'h20, 1'b0, 32'h0); i_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    i_valid = 1'b0;
    n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_held got %b exp 1", o_valid); end
    rst_n = 1'b0; i_ready = 1'b1; #1;
    model_reset();
    n_tests++; if (o_valid !== 1'b0 || o_pipe_flush !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_drop got valid=%b flush=%b exp 0/0", o_valid, o_pipe_flush); end
    @(negedge clk);
    rst_n = 1'b1; i_ready = 1'b0; #1;
    n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b exp 1", o_ready); end
    @(posedge clk); @(negedge clk);
    n_tests++; if (o_valid !== 1'b0 || o_mispredict_cnt !== '0) begin n_fail++;
      $display("FAIL rstmid_after got valid=%b cnt=%0d exp 0/0", o_valid, o_mispredict_cnt); end
    i_ready = 1'b1;
  endtask

  task automatic test_bht_sequence();
    for (int n = 0; n < 3; n++) test_single_txn(3'd0, 32'd9, 32'd9, 32'h80, 32'h0, 1'b1, 32'h80);
    i_lookup_pc = 32'h0; #1;
    n_tests++; if (o_lookup_taken !== 1'b1 || bht_m[0] != 3) begin n_fail++;
      $display("FAIL bht_saturate got %b exp 1 (model ctr %0d, exp 3)", o_lookup_taken, bht_m[0]); end
    test_single_txn(3'd0, 32'd1, 32'd2, 32'h80, 32'hFFFF_FFFC, 1'b0, 32'h0);  // wraps to 0
  endtask

  task automatic test_back_to_back();
    bit tk, mis;
    logic [31:0] tgt, lnk, pc;
    bit          e_mis [4];
    logic [31:0] e_pc  [4];
    logic [2:0]  e_op  [4];
    logic [31:0] e_in  [4];
    bit          e_tk  [4];
    // Hold a mispredicted result under backpressure
    model_eval(3'd2, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h300, tk, tgt, lnk);
    mis = model_mis(tk, 1'b0, tgt, 32'h0);
    drive_req(3'd2, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h300, 1'b0, 32'h0); i_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    i_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++; if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_pipe_flush !== 1'b0) begin n_fail++;
        $display("FAIL stall_ctrl c=%0d got valid=%b ready=%b flush=%b exp 1/0/0", c, o_valid, o_ready, o_pipe_flush); end
      n_tests++; if (o_pc !== tgt || o_taken !== tk || o_link !== lnk) begin n_fail++;
        $display("FAIL stall_hold c=%0d got pc=%h taken=%b link=%h exp %h/%b/%h", c, o_pc, o_taken, o_link, tgt, tk, lnk); end
      @(posedge clk); @(negedge clk);
    end
    i_ready = 1'b1;
    // First of four beq enters in the release cycle
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a, b, pt;
      bit pf;
      pc = 32'($urandom_range(0, 255) * 4);
      a  = $urandom; b = ($urandom_range(0, 1) != 0) ? a : a ^ 32'h10;
      pf = 1'($urandom_range(0, 1));
      model_eval(3'd0, a, b, 32'h100, pc, e_tk[k], e_pc[k], lnk);
      pt = ($urandom_range(0, 1) != 0) ? e_pc[k] : e_pc[k] + 32'd8;
      e_mis[k] = model_mis(e_tk[k], pf, e_pc[k], pt);
      e_op[k] = 3'd0; e_in[k] = pc;
      if (k == 0) drive_req(3'd0, a, b, 32'h100, pc, pf, pt);
      else begin
        // stash stimulus for later cycles in the same arrays
        e_in[k] = pc;
      end
      if (k > 0) begin
        // stimulus for k>0 is re-driven below; keep operands compactly in locals
      end
      if (k == 0) begin
        #1;
        n_tests++; if (o_pipe_flush !== mis) begin n_fail++; $display("FAIL stall_release got %b exp %b", o_pipe_flush, mis); end
        model_commit(3'd2, 32'h300, tk, mis);
        @(posedge clk); @(negedge clk);
      end else begin
        drive_req(3'd0, a, b, 32'h100, pc, pf, pt);
        #1;
        n_tests++; if (o_valid !== 1'b1 || o_pc !== e_pc[k-1] || o_pipe_flush !== e_mis[k-1]) begin n_fail++;
          $display("FAIL b2b k=%0d got valid=%b pc=%h flush=%b exp 1/%h/%b", k-1, o_valid, o_pc, o_pipe_flush, e_pc[k-1], e_mis[k-1]); end
        model_commit(e_op[k-1], e_in[k-1], e_tk[k-1], e_mis[k-1]);
        @(posedge clk); @(negedge clk);
      end
    end
    i_valid = 1'b0; #1;
    n_tests++; if (o_valid !== 1'b1 || o_pc !== e_pc[3] || o_pipe_flush !== e_mis[3]) begin n_fail++;
      $display("FAIL b2b k=3 got valid=%b pc=%h flush=%b exp 1/%h/%b", o_valid, o_pc, o_pipe_flush, e_pc[3], e_mis[3]); end
    model_commit(e_op[3], e_in[3], e_tk[3], e_mis[3]);
    @(posedge clk); @(negedge clk);
    n_tests++; if (o_valid !== 1'b0 || o_mispredict_cnt !== CNT_WIDTH'(cnt_m)) begin n_fail++;
      $display("FAIL b2b_end got valid=%b cnt=%0d exp 0/%0d", o_valid, o_mispredict_cnt, cnt_m); end
  endtask

  task automatic test_kill();
    drive_req(3'd0, 32'd5, 32'd5, 32'h10, 32'h40, 1'b0, 32'h0); i_ready = 1'b0;  // taken, predicted not
    @(posedge clk); @(negedge clk);
    n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL kill_held got %b exp 1", o_valid); end
    i_kill = 1'b1; i_ready = 1'b1;
    drive_req(3'd1, 32'd1, 32'd2, 32'h10, 32'h80, 1'b0, 32'h0);                   // discarded request
    #1;
    n_tests++; if (o_pipe_flush !== 1'b0) begin n_fail++; $display("FAIL kill_flush got %b exp 0", o_pipe_flush); end
    @(posedge clk); @(negedge clk);
    i_kill = 1'b0; i_valid = 1'b0;
    n_tests++; if (o_valid !== 1'b0 || o_mispredict_cnt !== CNT_WIDTH'(cnt_m)) begin n_fail++;
      $display("FAIL kill_clear got valid=%b cnt=%0d exp 0/%0d", o_valid, o_mispredict_cnt, cnt_m); end
    i_lookup_pc = 32'h40; #1;
    n_tests++; if (o_lookup_taken !== pred_bit(32'h40)) begin n_fail++;
      $display("FAIL kill_bht40 got %b exp %b", o_lookup_taken, pred_bit(32'h40)); end
    i_lookup_pc = 32'h80; #1;
    n_tests++; if (o_lookup_taken !== pred_bit(32'h80)) begin n_fail++;
      $display("FAIL kill_bht80 got %b exp %b", o_lookup_taken, pred_bit(32'h80)); end
    @(posedge clk); @(negedge clk);
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL kill_discard got %b exp 0", o_valid); end
  endtask

  task automatic test_random();
    bit          m_valid = 1'b0, m_tk = 1'b0, m_mis = 1'b0;
    logic [31:0] m_pc = '0, m_link = '0, m_in = '0;
    logic [2:0]  m_op = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit          tk, pf, accept, xfer;
      logic [31:0] tgt, lnk, a, b, imm, pc, pt;
      logic [2:0]  op;
      n_tests++; if (o_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got %b exp %b", cyc, o_valid, m_valid); end
      if (m_valid) begin
        n_tests++; if (o_taken !== m_tk || o_pc !== m_pc || o_link !== m_link) begin n_fail++;
          $display("FAIL rnd_result cyc=%0d got %b/%h/%h exp %b/%h/%h", cyc, o_taken, o_pc, o_link, m_tk, m_pc, m_link); end
      end
      n_tests++; if (o_mispredict_cnt !== CNT_WIDTH'(cnt_m)) begin n_fail++;
        $display("FAIL rnd_cnt cyc=%0d got %0d exp %0d", cyc, o_mispredict_cnt, cnt_m); end
      op  = 3'($urandom_range(0, 7));
      a   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      b   = ($urandom_range(0, 2) == 0) ? a : $urandom;
      imm = $urandom; pc = $urandom & 32'hFFFF_FFFC;
      pf  = 1'($urandom_range(0, 1));
      model_eval(op, a, b, imm, pc, tk, tgt, lnk);
      pt  = ($urandom_range(0, 2) != 0) ? tgt : $urandom;
      drive_req(op, a, b, imm, pc, pf, pt);
      i_valid = 1'($urandom_range(0, 1));
      i_ready = ($urandom_range(0, 3) != 0);
      i_lookup_pc = m_in; #1;
      n_tests++; if (o_ready !== (!m_valid || i_ready)) begin n_fail++;
        $display("FAIL rnd_ready cyc=%0d got %b exp %b", cyc, o_ready, (!m_valid || i_ready)); end
      n_tests++; if (o_pipe_flush !== (m_valid && i_ready && m_mis)) begin n_fail++;
        $display("FAIL rnd_flush cyc=%0d got %b exp %b", cyc, o_pipe_flush, (m_valid && i_ready && m_mis)); end
      n_tests++; if (o_lookup_taken !== pred_bit(m_in)) begin n_fail++;
        $display("FAIL rnd_lookup cyc=%0d got %b exp %b", cyc, o_lookup_taken, pred_bit(m_in)); end
      xfer   = m_valid && i_ready;
      accept = i_valid && (!m_valid || i_ready);
      if (xfer) model_commit(m_op, m_in, m_tk, m_mis);
      if (accept) begin
        m_valid = 1'b1; m_tk = tk; m_pc = tgt; m_link = lnk; m_op = op; m_in = pc;
        m_mis = model_mis(tk, pf, tgt, pt);
      end else if (xfer) begin
        m_valid = 1'b0;
      end
      @(posedge clk); @(negedge clk);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_bht_sequence();
    test_back_to_back();
    test_kill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exu_bru.md
EXU_BRU -- requirements
Module: exu_bru

Interface
REQ-001 Parameter XLEN, default 32, operand and PC width.
REQ-002 Parameter BHT_DEPTH, default 16, number of 2-bit predictor counters, power of two, >= 2.
REQ-003 Parameter CNT_WIDTH, default 16, mispredict counter width.
REQ-004 Ports: clk, in, 1, clock; rst_n, in, 1, reset; one clock, asynchronous active-low reset.
REQ-005 Input-side ports: i_valid, in, 1, request; o_ready, out, 1, request accepted.
REQ-006 Input-side ports: i_op, in, 3, operation code: 0 beq, 1 bne, 2 blt, 3 bge, 4 bltu, 5 bgeu, 6 jal, 7 jalr.
REQ-007 Operand ports: i_rs1, in, XLEN; i_rs2, in, XLEN; i_imm, in, XLEN; i_pc, in, XLEN.
REQ-008 Prediction ports: i_predict_flag, in, 1, front end predicted taken; i_predict_target, in, XLEN, predicted target.
REQ-009 Result ports: o_valid, out, 1; i_ready, in, 1; o_taken, out, 1; o_pc, out, XLEN, resolved next PC; o_link, out, XLEN, i_pc+4.
REQ-010 Control ports: o_pipe_flush, out, 1, mispredict redirect pulse; i_kill, in, 1, discard held result.
REQ-011 Lookup ports: i_lookup_pc, in, XLEN; o_lookup_taken, out, 1; o_mispredict_cnt, out, CNT_WIDTH.

Function
REQ-012 o_ready SHALL equal ~o_valid | i_ready; a request SHALL be accepted on a rising clk edge when i_valid & o_ready.
REQ-013 An accepted request SHALL appear on the result ports one cycle later, registered, and SHALL be held stable while o_valid & ~i_ready.
REQ-014 Compares: blt/bge SHALL be signed, bltu/bgeu unsigned, beq/bne equality, all over XLEN bits.
REQ-015 Taken SHALL be the compare result for ops 0-5 and 1 for jal/jalr.
REQ-016 Target SHALL be i_pc+i_imm for taken ops 0-6; for jalr it SHALL be (i_rs1+i_imm) with bit 0 cleared; for not-taken it SHALL be i_pc+4. All sums SHALL wrap modulo 2^XLEN.
REQ-017 o_pc SHALL be the target; o_link SHALL be i_pc+4 (wrapping) for every op.
REQ-018 A mispredict SHALL occur when taken != i_predict_flag, or when taken & i_predict_flag & target != i_predict_target.
REQ-019 o_pipe_flush SHALL be 1 for exactly the transfer cycle (o_valid & i_ready) of a mispredicted result, and 0 otherwise.
REQ-020 i_kill SHALL clear o_valid on the next edge without flush, BHT update or count; a request accepted in the same cycle as i_kill SHALL be discarded.
REQ-021 The BHT SHALL be indexed by pc[2 +: log2(BHT_DEPTH)].
REQ-022 On transfer of a conditional result (ops 0-5), the counter SHALL increment if taken (saturating at 3) and decrement if not taken (saturating at 0); jal/jalr SHALL NOT update it.
REQ-023 o_lookup_taken SHALL be combinational counter[i_lookup_pc index] bit 1; a same-cycle lookup and update of one index SHALL return the pre-update value.
REQ-024 o_mispredict_cnt SHALL increment on each o_pipe_flush and saturate at all-ones.
REQ-025 Back-to-back transfers SHALL sustain one result per cycle while i_ready is held high.

Reset
REQ-026 While rst_n is low: o_valid, o_taken, o_pc, o_link, o_pipe_flush SHALL be 0, o_mispredict_cnt SHALL be 0, and all BHT counters SHALL be 2'b01.
REQ-027 A reset asserted mid-transaction SHALL drop the held result with no flush; o_ready SHALL be 1 the first cycle after release.

Verification
REQ-028 blt, rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20, predict 0 -> o_taken=1, o_pc=0x120, o_pipe_flush pulses once, cnt=1.
REQ-029 bltu with the same operands, predict 0 -> o_taken=0, o_pc=0x104, no flush; BHT index 0 goes 01->00, lookup pc=0x100 gives 0.
REQ-030 jalr, rs1=0x203, imm=0, predict 1, target 0x202 -> o_pc=0x202, o_link=pc+4, no flush; repeat with target 0x200 -> flush.
REQ-031 i_ready=0 for 3 cycles with o_valid=1 -> outputs stable, o_ready=0, flush only in the release cycle; then 4 back-to-back beq -> 4 results in 4 cycles.
REQ-032 i_kill while a mispredicted result is held -> o_valid=0 next cycle, no flush, BHT and cnt unchanged.
REQ-033 Three taken beq at pc=0x0 -> counter 01->10->11->11, o_lookup_taken=1 after the first update; pc=0xFFFFFFFC not taken -> o_pc=0x0 (wrap).
